hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage 64-bit RISC-V core. Drives PC, IF/ID and ID/EX enables, bubble and flush.
//  Covers three cases: a multi-cycle MUL held in EX for MUL_LAT cycles, a load-use hazard, and a branch operand hazard.
//  Also flushes IF/ID on a taken branch or jump resolved in ID, and counts stall cycles for performance readout.
// PARAMETERS
//  MUL_LAT  4   cycles a MUL occupies EX (1..15); 1 = single-cycle, never freezes
//  CNT_W    32  width of stall_cycles performance counter
// PORTS
//  clk             in   1      main clock
//  arst_n          in   1      asynchronous active-low reset
//  enable          in   1      core run enable; 0 freezes the whole pipeline and this block
//  id_rs1, id_rs2  in   5      source register fields of the instruction in ID
//  id_uses_rs1/2   in   1      ID instruction reads rs1 / rs2
//  id_is_branch    in   1      ID instruction is a conditional branch (compares in ID)
//  id_ex_rd        in   5      destination register of the instruction in EX
//  id_ex_reg_write in   1      EX instruction writes the register file
//  id_ex_mem_read  in   1      EX instruction is a load
//  id_ex_is_mul    in   1      EX instruction is a MUL
//  ex_m_rd         in   5      destination register of the instruction in MEM
//  ex_m_mem_read   in   1      MEM instruction is a load
//  branch_taken    in   1      ID branch comparison true AND branch (raw, unqualified)
//  jump            in   1      ID instruction is a jump
//  pc_en           out  1      PC register load enable
//  if_id_en        out  1      IF/ID register enable
//  if_id_flush     out  1      load NOP (0x00000013) into IF/ID at next edge
//  id_ex_en        out  1      ID/EX register enable
//  id_ex_bubble    out  1      clear ID/EX control fields at next edge
//  ex_m_bubble     out  1      clear EX/MEM control fields at next edge
//  mul_start       out  1      one-cycle pulse: multiplier begins operand capture
//  mul_busy        out  1      FSM is in MUL_BUSY
//  stall_cycles    out  CNT_W  saturating count of cycles with pc_en==0 while enable==1
// BEHAVIOUR
//  - Reset (arst_n low): state=RUN, cnt=0, stall_cycles=0.
//  - Outputs are combinational from state/cnt/inputs, all ANDed with enable.
//  - Hence with enable=0 (mandatory during reset): every output = 0 except stall_cycles, which holds.
//  - FSM states RUN, MUL_BUSY; 4-bit counter cnt. Transitions only on enabled edges.
//  - mul_freeze = (RUN & id_ex_is_mul & MUL_LAT>1) | (MUL_BUSY & cnt!=MUL_LAT-1).
//  - RUN -> MUL_BUSY when mul_freeze: cnt<=1, mul_start=1 that cycle only.
//  - MUL_BUSY: cnt<=cnt+1. On cnt==MUL_LAT-1: freeze drops, ID/EX advances, next state RUN.
//  - Total freeze = MUL_LAT-1 cycles. Back-to-back MULs re-trigger immediately.
//  - During mul_freeze: pc_en=if_id_en=id_ex_en=0, ex_m_bubble=1, id_ex_bubble=0, if_id_flush=0.
//  - load_use (RUN only) = id_ex_mem_read & id_ex_rd!=0 & ((id_uses_rs1 & rd==id_rs1) | (id_uses_rs2 & rd==id_rs2)).
//  - br_haz (RUN only) = id_is_branch & match on id_ex_rd (id_ex_reg_write) or on ex_m_rd (ex_m_mem_read), rd!=0.
//  - stall = load_use | br_haz. It gives pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1 for exactly that cycle.
//  - redirect = (branch_taken | jump) & !stall & !mul_freeze.
//  - On redirect: pc_en=1, if_id_en=1, if_id_flush=1. This is a 1-bubble penalty.
//  - Raw branch_taken is ignored while stalled, because its operands are stale.
//  - Otherwise: pc_en=if_id_en=id_ex_en=1 and all bubbles/flush = 0.
//  - Priority: mul_freeze > stall > redirect. MUL and load in EX together is illegal (assertion).
//  - enable falling mid-MUL_BUSY: state and cnt hold. Sequence resumes at the same cnt when enable returns.
//  - arst_n mid-MUL_BUSY: immediate return to RUN, cnt=0. No mul_start is emitted until a new MUL is in EX.
//  - stall_cycles increments when enable & !pc_en, and saturates at all-ones.
// STRUCTURE
//  - Shared package cpu_ctrl_pkg: state encoding (RUN=1'b0, MUL_BUSY=1'b1) and NOP_INSTR=32'h00000013.
//  - Sub-module hazard_detect (combinational): computes load_use and br_haz from register fields.
//  - FSM, counter and output logic stay in hazard_stall_ctrl.
//  - The core instantiates this block in cpu and replaces the tied-high enables of the PC and IF/ID/ID/EX registers.
// TESTING
//  1 MUL_LAT=4, MUL x5 enters EX:
//      mul_start high 1 cycle; pc_en=0 for 3 cycles; ex_m_bubble=1 for 3 cycles; stall_cycles=3; back to RUN.
//  2 ld x7 in EX, ID add x8,x7,x1:
//      1 cycle pc_en=0, id_ex_bubble=1; next cycle pc_en=1. Same with rd=x0 -> no stall.
//  3 beq x3,x4 in ID with x3 loaded by MEM-stage ld, branch_taken=1:
//      stall 1 cycle, if_id_flush=0; after the stall, branch_taken=1 -> if_id_flush=1, pc_en=1.
//  4 jump in ID while MUL freezes:
//      if_id_flush stays 0 until cnt==MUL_LAT-1; flush asserted on the first unfrozen cycle.
//  5 enable=0 at cnt=2, hold 5 cycles, re-enable:
//      outputs 0 while disabled; freeze resumes, 1 more cycle, total stall_cycles=3.
//  6 arst_n pulse at cnt=2:
//      mul_busy=0, stall_cycles=0; no mul_start until a new MUL reaches EX; MUL_LAT=1 build -> zero freezes.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-control types: sequencer state encoding, the IF/ID flush NOP and a register-hit helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Destination rd feeds a source actually read by the ID instruction; x0 never creates a dependency.
    function automatic logic src_hit(input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic use1,
                                     input logic [4:0] rs2, input logic use2);
        return (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard/stall sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: the slave's enables and bubbles are the pipeline's backpressure.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_is_branch;
    logic [4:0]       id_ex_rd;
    logic             id_ex_reg_write;
    logic             id_ex_mem_read;
    logic             id_ex_is_mul;
    logic [4:0]       ex_m_rd;
    logic             ex_m_mem_read;
    logic             branch_taken;
    logic             jump;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_bubble;
    logic             ex_m_bubble;
    logic             mul_start;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read, id_ex_is_mul,
               ex_m_rd, ex_m_mem_read, branch_taken, jump,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_m_bubble, mul_start, mul_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read, id_ex_is_mul,
               ex_m_rd, ex_m_mem_read, branch_taken, jump,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_m_bubble, mul_start, mul_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use and branch-operand hazard detection from the ID/EX/MEM register fields.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the results with its own state.
module hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_is_branch,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_reg_write,
    input  logic       id_ex_mem_read,
    input  logic [4:0] ex_m_rd,
    input  logic       ex_m_mem_read,
    output logic       load_use,
    output logic       br_haz
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit   = src_hit(id_ex_rd, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2);
        mem_hit  = src_hit(ex_m_rd, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2);
        load_use = id_ex_mem_read && ex_hit;
        // Branches compare in ID, so any pending EX result or a load still in MEM is not forwardable.
        br_haz   = id_is_branch && ((id_ex_reg_write && ex_hit) || (ex_m_mem_read && mem_hit));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: MUL freeze, load-use / branch-operand stalls, ID redirect flush, stall counter.
// Latency: enables/bubbles combinational from state and inputs; state and counter update on enabled edges.
// Backpressure: mul_freeze > stall > redirect; enable=0 forces every control output low and holds all state.
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               enable,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [3:0] CNT_LAST  = 4'(MUL_LAT - 1);
    localparam logic       MUL_MULTI = (MUL_LAT > 1);

    ctrl_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use, br_haz;
    logic mul_freeze, stall, redirect;
    logic pc_en_w, if_id_en_w, if_id_flush_w, id_ex_en_w, id_ex_bubble_w, ex_m_bubble_w;

    hazard_detect u_hazard_detect (
        .id_rs1          (bus.id_rs1),
        .id_rs2          (bus.id_rs2),
        .id_uses_rs1     (bus.id_uses_rs1),
        .id_uses_rs2     (bus.id_uses_rs2),
        .id_is_branch    (bus.id_is_branch),
        .id_ex_rd        (bus.id_ex_rd),
        .id_ex_reg_write (bus.id_ex_reg_write),
        .id_ex_mem_read  (bus.id_ex_mem_read),
        .ex_m_rd         (bus.ex_m_rd),
        .ex_m_mem_read   (bus.ex_m_mem_read),
        .load_use        (load_use),
        .br_haz          (br_haz)
    );

    always_comb begin
        mul_freeze = ((state_q == RUN) && bus.id_ex_is_mul && MUL_MULTI)
                  || ((state_q == MUL_BUSY) && (cnt_q != CNT_LAST));
        stall      = (state_q == RUN) && (load_use || br_haz);
        // A raw branch_taken during a stall was computed from stale operands and must not redirect.
        redirect   = (bus.branch_taken || bus.jump) && !stall && !mul_freeze;

        pc_en_w        = 1'b1;
        if_id_en_w     = 1'b1;
        if_id_flush_w  = 1'b0;
        id_ex_en_w     = 1'b1;
        id_ex_bubble_w = 1'b0;
        ex_m_bubble_w  = 1'b0;
        if (mul_freeze) begin
            pc_en_w       = 1'b0;
            if_id_en_w    = 1'b0;
            id_ex_en_w    = 1'b0;
            ex_m_bubble_w = 1'b1;
        end else if (stall) begin
            pc_en_w        = 1'b0;
            if_id_en_w     = 1'b0;
            id_ex_bubble_w = 1'b1;
        end else begin
            if_id_flush_w = redirect;
        end

        bus.pc_en        = enable && pc_en_w;
        bus.if_id_en     = enable && if_id_en_w;
        bus.if_id_flush  = enable && if_id_flush_w;
        bus.id_ex_en     = enable && id_ex_en_w;
        bus.id_ex_bubble = enable && id_ex_bubble_w;
        bus.ex_m_bubble  = enable && ex_m_bubble_w;
        bus.mul_start    = enable && (state_q == RUN) && mul_freeze;
        bus.mul_busy     = enable && (state_q == MUL_BUSY);
        bus.stall_cycles = stall_cycles_q;

        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;
        if (enable) begin
            if (state_q == RUN) begin
                if (mul_freeze) begin
                    state_d = MUL_BUSY;
                    cnt_d   = 4'd1;
                end
            end else if (cnt_q == CNT_LAST) begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            if (!pc_en_w && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    a_no_mul_and_load: assert property (@(posedge clk) disable iff (!arst_n)
        enable |-> !(bus.id_ex_is_mul && bus.id_ex_mem_read));

endmodule
